tbc_bus_arbiter: RTL and testbench

- Shares the single TBC register bus (addr/data/wr/rd with ack/nack/unknown responses) between NREQ requesters, e.g. the serial command bridge and on-chip sequencers.
- Arbitrates round-robin and runs one bus transaction at a time.
- Enforces a response timeout and returns status and read data to the granted requester.
- Sits between requesters and the TBC register decode at the 0x9000–0x9FFF window.

---
 rtl/tbc_bus_pkg.sv | 36 +++
 rtl/tbc_bus_arbiter_rr_arbiter.sv | 37 +++
 rtl/tbc_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_tbc_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tbc_bus_pkg.sv
// Shared definitions for the TBC register-bus arbiter: response status
// codes, arbiter FSM encodings, the register window constants and the
// status priority helper.
package tbc_bus_pkg;

  // Response status codes returned to the requester with rsp_done.
  localparam logic [1:0] ST_ACK  = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_UNK  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  // TBC register decode window (0x9000-0x9FFF).
  localparam logic [15:0] WIN_BASE = 16'h9000;
  localparam logic [15:0] WIN_MASK = 16'hF000;

  // Arbiter FSM: one bus transaction at a time.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } arb_state_e;

  // Map a bus response to a status code; nack beats unknown beats ack.
  function automatic logic [1:0] resp_status(input logic nack_i, input logic unknown_i);
    logic [1:0] st;
    if (nack_i) begin
      st = ST_NACK;
    end else if (unknown_i) begin
      st = ST_UNK;
    end else begin
      st = ST_ACK;
    end
    return st;
  endfunction

endpackage

// File: rtl/tbc_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the lowest requesting index at
// or after ptr_i, wrapping modulo NREQ. ptr_i must be below NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  int best_s;

  // Distance of requester idx from the pointer in round-robin order.
  function automatic int rr_dist(input int idx, input int ptr);
    return (idx + NREQ - ptr) % NREQ;
  endfunction

  // Find the closest requester in round-robin order, then one-hot grant it.
  always_comb begin
    best_s  = NREQ;
    gnt_o   = '0;
    valid_o = |req_i;
    for (int i = 0; i < NREQ; i++) begin
      if (req_i[i] && (rr_dist(i, int'(ptr_i)) < best_s)) begin
        best_s = rr_dist(i, int'(ptr_i));
      end else begin
        best_s = best_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = req_i[i] && (rr_dist(i, int'(ptr_i)) == best_s);
    end
  end

endmodule

// File: rtl/tbc_bus_arbiter.sv
// Round-robin arbiter sharing the TBC register bus between NREQ requesters.
// Runs one transaction at a time (IDLE -> ACCESS -> DONE -> IDLE), enforces
// a response timeout and returns status and read data to the granted
// requester. All outputs are registered.
// Optional build macro ADDR_WINDOW_CHECK_EN: requests outside 0x9000-0x9FFF
// are answered with status unknown without touching the bus.
module tbc_bus_arbiter
  import tbc_bus_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int AW          = 16,
  parameter int DW          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_done,
  output logic [1:0]           rsp_status,
  output logic [DW-1:0]        rsp_rdata,
  output logic [AW-1:0]        addr,
  output logic [DW-1:0]        data,
  output logic                 wr,
  output logic                 rd,
  input  logic [DW-1:0]        rdata,
  input  logic                 ack,
  input  logic                 nack,
  input  logic                 unknown,
  output logic                 timeout,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wr_op_q, wr_op_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]   rsp_done_q, rsp_done_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   gnt_s;
  logic              gnt_valid_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [AW-1:0]     addr_sel_s;
  logic [DW-1:0]     wdata_sel_s;
  logic              wr_sel_s;
  logic              any_rsp_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_s),
    .valid_o (gnt_valid_s)
  );

  // Encode the one-hot grant and mux out the granted request fields.
  always_comb begin
    gnt_idx_s   = '0;
    addr_sel_s  = '0;
    wdata_sel_s = '0;
    wr_sel_s    = |(gnt_s & req_wr);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        gnt_idx_s   = IW'(i);
        addr_sel_s  = req_addr[i*AW +: AW];
        wdata_sel_s = req_wdata[i*DW +: DW];
      end else begin
        gnt_idx_s   = gnt_idx_s;
      end
    end
  end

  assign any_rsp_s = ack | nack | unknown;

`ifdef ADDR_WINDOW_CHECK_EN
  logic in_window_s;
  assign in_window_s = ((addr_sel_s[15:0] & WIN_MASK) == WIN_BASE);
`endif

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    wr_op_d      = wr_op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    rsp_done_d   = '0;
    rsp_status_d = ST_ACK;
    rsp_rdata_d  = '0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s) begin
          idx_d   = gnt_idx_s;
          wr_op_d = wr_sel_s;
          addr_d  = addr_sel_s;
          data_d  = wdata_sel_s;
          cnt_d   = 16'd0;
`ifdef ADDR_WINDOW_CHECK_EN
          if (!in_window_s) begin
            // Outside the register window: answer locally, no bus cycle.
            state_d      = S_DONE;
            rsp_done_d   = gnt_s;
            rsp_status_d = ST_UNK;
          end else begin
            wr_d    = wr_sel_s;
            rd_d    = !wr_sel_s;
            state_d = S_ACCESS;
          end
`else
          wr_d    = wr_sel_s;
          rd_d    = !wr_sel_s;
          state_d = S_ACCESS;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 16'd1;
        if (any_rsp_s) begin
          // A response wins even when it lands on the expiry cycle.
          wr_d         = 1'b0;
          rd_d         = 1'b0;
          state_d      = S_DONE;
          rsp_done_d   = NREQ'(1) << idx_q;
          rsp_status_d = resp_status(nack, unknown);
          if (!nack && !unknown && !wr_op_q) begin
            rsp_rdata_d = rdata;
          end else begin
            rsp_rdata_d = '0;
          end
        end else if (cnt_q == TMO_LAST) begin
          wr_d         = 1'b0;
          rd_d         = 1'b0;
          state_d      = S_DONE;
          rsp_done_d   = NREQ'(1) << idx_q;
          rsp_status_d = ST_TMO;
          timeout_d    = 1'b1;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_DONE: begin
        if (idx_q == IW'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = idx_q + IW'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      wr_op_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      cnt_q        <= 16'd0;
      rsp_done_q   <= '0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      wr_op_q      <= wr_op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      rsp_done_q   <= rsp_done_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_done   = rsp_done_q;
  assign rsp_status = rsp_status_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign wr         = wr_q;
  assign rd         = rd_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tbc_bus_arbiter.sv
// Directed testbench for tbc_bus_arbiter (NREQ=2, TIMEOUT_CYC=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_tbc_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int TMO  = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_wr = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_wdata = '0;
  logic [NREQ-1:0]     rsp_done;
  logic [1:0]          rsp_status;
  logic [DW-1:0]       rsp_rdata;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       data;
  logic                wr, rd;
  logic [DW-1:0]       rdata = '0;
  logic                ack = 1'b0, nack = 1'b0, unknown = 1'b0;
  logic                timeout, busy;

  int n_pass  = 0;
  int n_total = 0;

  tbc_bus_arbiter #(
    .NREQ(NREQ), .TIMEOUT_CYC(TMO), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .addr(addr), .data(data), .wr(wr), .rd(rd), .rdata(rdata),
    .ack(ack), .nack(nack), .unknown(unknown),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    chk("wr_rd_exclusive", 64'(wr & rd), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_done"},   64'(rsp_done),   64'd0);
    chk({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
    chk({tag, "_rsp_rdata"},  64'(rsp_rdata),  64'd0);
    chk({tag, "_addr"},       64'(addr),       64'd0);
    chk({tag, "_data"},       64'(data),       64'd0);
    chk({tag, "_wr"},         64'(wr),         64'd0);
    chk({tag, "_rd"},         64'(rd),         64'd0);
    chk({tag, "_timeout"},    64'(timeout),    64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
  endtask

  initial begin
    // Reset state
    step(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(1);
    chk_all_zero("post_reset_idle");

    // Requester 0 writes 0x9010 = DEADBEEF, ack while wr is in its 3rd cycle
    req_valid = 2'b01; req_wr = 2'b01;
    req_addr  = {16'h0000, 16'h9010};
    req_wdata = {32'h0, 32'hDEADBEEF};
    step(1);
    chk("w0_wr", 64'(wr), 64'd1);
    chk("w0_rd", 64'(rd), 64'd0);
    chk("w0_addr", 64'(addr), 64'h9010);
    chk("w0_data", 64'(data), 64'hDEADBEEF);
    chk("w0_busy", 64'(busy), 64'd1);
    step(1);
    chk("w0_wr_c2", 64'(wr), 64'd1);
    step(1);
    chk("w0_wr_c3", 64'(wr), 64'd1);
    ack = 1'b1;
    step(1);
    chk("w0_wr_drop", 64'(wr), 64'd0);
    chk("w0_done", 64'(rsp_done), 64'b01);
    chk("w0_status", 64'(rsp_status), 64'd0);
    chk("w0_rdata", 64'(rsp_rdata), 64'd0);
    chk("w0_busy_done", 64'(busy), 64'd1);
    ack = 1'b0; req_valid = 2'b00;
    step(1);
    chk("w0_done_clear", 64'(rsp_done), 64'd0);
    chk("w0_idle_busy", 64'(busy), 64'd0);

    // Requester 1 reads 0x9020, acked with 0x12345678
    req_valid = 2'b10; req_wr = 2'b00;
    req_addr  = {16'h9020, 16'h0000};
    step(1);
    chk("r1_rd", 64'(rd), 64'd1);
    chk("r1_wr", 64'(wr), 64'd0);
    chk("r1_addr", 64'(addr), 64'h9020);
    ack = 1'b1; rdata = 32'h12345678;
    step(1);
    chk("r1_rd_drop", 64'(rd), 64'd0);
    chk("r1_done", 64'(rsp_done), 64'b10);
    chk("r1_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("r1_status", 64'(rsp_status), 64'd0);
    ack = 1'b0; rdata = 32'h0; req_valid = 2'b00;
    step(1);
    chk("r1_done_clear", 64'(rsp_done), 64'd0);
    chk("r1_rdata_clear", 64'(rsp_rdata), 64'd0);

    // Both requesters continuously valid and acked: 0,1,0 then reset
    req_valid = 2'b11; req_wr = 2'b11;
    req_addr  = {16'h9200, 16'h9100};
    req_wdata = {32'h22222222, 32'h11111111};
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("rr_wr", 64'(wr), 64'd1);
      chk("rr_addr", 64'(addr), (k % 2 == 0) ? 64'h9100 : 64'h9200);
      chk("rr_data", 64'(data), (k % 2 == 0) ? 64'h11111111 : 64'h22222222);
      step(1);
      chk("rr_done", 64'(rsp_done), (k % 2 == 0) ? 64'b01 : 64'b10);
      step(1);
      chk("rr_gap_wr", 64'(wr), 64'd0);
      chk("rr_gap_done", 64'(rsp_done), 64'd0);
      chk("rr_gap_busy", 64'(busy), 64'd0);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rr_after_reset_addr", 64'(addr), 64'h9100);
    chk("rr_after_reset_wr", 64'(wr), 64'd1);
    step(1);
    chk("rr_after_reset_done", 64'(rsp_done), 64'b01);
    ack = 1'b0; req_valid = 2'b00;
    step(1);

    // Requester 1 read with no response: timeout after 8 strobe cycles
    req_valid = 2'b10; req_wr = 2'b00;
    req_addr  = {16'h9030, 16'h9040};
    step(1);
    chk("tmo_rd", 64'(rd), 64'd1);
    step(TMO - 1);
    chk("tmo_rd_last", 64'(rd), 64'd1);
    chk("tmo_not_yet", 64'(timeout), 64'd0);
    step(1);
    chk("tmo_pulse", 64'(timeout), 64'd1);
    chk("tmo_rd_drop", 64'(rd), 64'd0);
    chk("tmo_done", 64'(rsp_done), 64'b10);
    chk("tmo_status", 64'(rsp_status), 64'b11);
    chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
    req_valid = 2'b00;
    step(1);
    chk("tmo_pulse_end", 64'(timeout), 64'd0);

    // Requester 0 read, ack exactly on the expiry cycle: ack wins
    req_valid = 2'b01;
    step(1);
    chk("tie_rd", 64'(rd), 64'd1);
    step(TMO - 1);
    chk("tie_rd_last", 64'(rd), 64'd1);
    ack = 1'b1; rdata = 32'hA5A5A5A5;
    step(1);
    chk("tie_done", 64'(rsp_done), 64'b01);
    chk("tie_status", 64'(rsp_status), 64'd0);
    chk("tie_no_timeout", 64'(timeout), 64'd0);
    chk("tie_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
    ack = 1'b0; rdata = 32'h0; req_valid = 2'b00;
    step(1);

    // Requester 1 write, nack and unknown together: nack wins
    req_valid = 2'b10; req_wr = 2'b10;
    req_addr  = {16'h9050, 16'h9060};
    step(1);
    chk("nk_wr", 64'(wr), 64'd1);
    nack = 1'b1; unknown = 1'b1;
    step(1);
    chk("nk_done", 64'(rsp_done), 64'b10);
    chk("nk_status", 64'(rsp_status), 64'b01);
    nack = 1'b0; unknown = 1'b0; req_valid = 2'b00;
    step(1);

    // Requester 0 read, unknown alone: status 10 and rdata forced to 0
    req_valid = 2'b01; req_wr = 2'b00;
    step(1);
    chk("unk_rd", 64'(rd), 64'd1);
    chk("unk_addr", 64'(addr), 64'h9060);
    unknown = 1'b1; rdata = 32'hFFFF0000;
    step(1);
    chk("unk_done", 64'(rsp_done), 64'b01);
    chk("unk_status", 64'(rsp_status), 64'b10);
    chk("unk_rdata", 64'(rsp_rdata), 64'd0);
    unknown = 1'b0; rdata = 32'h0; req_valid = 2'b00;
    step(1);

    // Requester 1 write, reset mid-ACCESS: outputs clear at once, no rsp_done
    req_valid = 2'b10; req_wr = 2'b10;
    req_addr  = {16'h9070, 16'h9060};
    step(1);
    chk("rst_mid_wr", 64'(wr), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    req_valid = 2'b00;
    ack = 1'b1;
    step(1);
    chk("rst_mid_no_done", 64'(rsp_done), 64'd0);
    ack = 1'b0;
    rst_n = 1'b1;
    step(1);
    chk_all_zero("rst_mid_after");

`ifdef ADDR_WINDOW_CHECK_EN
    // Out-of-window request: no strobe, rsp_done next cycle with status 10
    req_valid = 2'b01; req_wr = 2'b01;
    req_addr  = {16'h9070, 16'h8000};
    step(1);
    chk("win_wr", 64'(wr), 64'd0);
    chk("win_rd", 64'(rd), 64'd0);
    chk("win_done", 64'(rsp_done), 64'b01);
    chk("win_status", 64'(rsp_status), 64'b10);
    chk("win_rdata", 64'(rsp_rdata), 64'd0);
    req_valid = 2'b00;
    step(1);
    chk("win_done_clear", 64'(rsp_done), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
